// File: rtl/split_mem_arbiter_pkg.sv
// Shared types and constants for the split instruction/data memory arbiter.
// Lines are 256 bits and move to or from physical memory as four 64-bit beats.
package split_mem_arbiter_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 256;
    localparam int BEAT_W     = 64;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int OFFSET_W   = 5;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int WORD_IDX_W = OFFSET_W - 2;
    localparam int MBE_W      = WORD_W / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        MERGE    = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    typedef logic [LINE_W-1:0] line_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:2];
    endfunction

endpackage

// File: rtl/split_mem_arbiter_line_beat_buffer.sv
// One-line staging buffer: beat-wise fill from memory, byte-masked word merge,
// and beat/word read-out taken from the next-cycle value of the line.
module split_mem_arbiter_line_beat_buffer
    import split_mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [BEAT_IDX_W-1:0] load_beat,
    input  logic [BEAT_W-1:0]     load_data,
    input  logic                  merge_en,
    input  logic [WORD_IDX_W-1:0] word_idx,
    input  logic [WORD_W-1:0]     merge_word,
    input  logic [MBE_W-1:0]      merge_mbe,
    input  logic [BEAT_IDX_W-1:0] rd_beat,
    output logic [BEAT_W-1:0]     beat_out,
    output logic [WORD_W-1:0]     word_out
);

    line_t line_r;
    line_t line_n_s;

    // next line value: a returned beat, or the masked write word merged in
    always_comb begin
        line_n_s = line_r;
        if (load_en) begin
            line_n_s[{load_beat, 6'b000000} +: BEAT_W] = load_data;
        end else if (merge_en) begin
            for (int i = 0; i < MBE_W; i++) begin
                if (merge_mbe[i]) begin
                    line_n_s[{word_idx, 2'(i), 3'b000} +: 8] = merge_word[8*i +: 8];
                end else begin
                    line_n_s[{word_idx, 2'(i), 3'b000} +: 8] = line_r[{word_idx, 2'(i), 3'b000} +: 8];
                end
            end
        end else begin
            line_n_s = line_r;
        end
    end

    // Read-outs see the post-update line so registered consumers get fresh data.
    assign beat_out = line_n_s[{rd_beat, 6'b000000} +: BEAT_W];
    assign word_out = line_n_s[{word_idx, 5'b00000} +: WORD_W];

    // line storage
    always_ff @(posedge clk) begin
        if (rst) begin
            line_r <= {LINE_W{1'b0}};
        end else begin
            line_r <= line_n_s;
        end
    end

endmodule

// File: rtl/split_mem_arbiter.sv
// Arbitrates the core's instruction (a) and data (b) ports onto one line-granular
// burst memory; word writes are done as read-modify-write of the containing line.
module split_mem_arbiter
    import split_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              read_a,
    input  logic [ADDR_W-1:0] address_a,
    output logic [WORD_W-1:0] rdata_a,
    output logic              resp_a,
    input  logic              read_b,
    input  logic              write,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [WORD_W-1:0] wdata,
    input  logic [MBE_W-1:0]  mbe,
    output logic [WORD_W-1:0] rdata_b,
    output logic              resp_b,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    state_t                state_r;
    state_t                state_n_s;
    logic [BEAT_IDX_W-1:0] beat_r;
    logic [BEAT_IDX_W-1:0] beat_n_s;
    port_t                 last_grant_r;
    port_t                 gnt_port_r;
    port_t                 gnt_port_n_s;
    logic                  op_write_r;
    logic                  op_write_n_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [ADDR_W-1:0]     addr_n_s;
    logic [WORD_W-1:0]     wdata_r;
    logic [WORD_W-1:0]     wdata_n_s;
    logic [MBE_W-1:0]      mbe_r;
    logic [MBE_W-1:0]      mbe_n_s;
    logic                  req_a_s;
    logic                  req_b_s;
    logic                  grant_s;
    logic                  load_en_s;
    logic                  merge_en_s;
    logic                  last_beat_s;
    logic [BEAT_W-1:0]     beat_out_s;
    logic [WORD_W-1:0]     word_out_s;
    logic                  addr_lsb_unused_s;

    // Byte offset within the word never affects a word access.
    assign addr_lsb_unused_s = ^addr_r[1:0];

    // arbitration and request capture, only while idle
    always_comb begin
        req_a_s      = read_a;
        req_b_s      = read_b | write;
        grant_s      = 1'b0;
        gnt_port_n_s = gnt_port_r;
        op_write_n_s = op_write_r;
        addr_n_s     = addr_r;
        wdata_n_s    = wdata_r;
        mbe_n_s      = mbe_r;
        if ((state_r == IDLE) && (req_a_s || req_b_s)) begin
            grant_s = 1'b1;
            if (req_a_s && req_b_s) begin
                gnt_port_n_s = (last_grant_r == PORT_A) ? PORT_B : PORT_A;
            end else if (req_a_s) begin
                gnt_port_n_s = PORT_A;
            end else begin
                gnt_port_n_s = PORT_B;
            end
            // A simultaneous read_b/write is serviced as the write.
            if (gnt_port_n_s == PORT_A) begin
                op_write_n_s = 1'b0;
                addr_n_s     = address_a;
                wdata_n_s    = {WORD_W{1'b0}};
                mbe_n_s      = {MBE_W{1'b0}};
            end else begin
                op_write_n_s = write;
                addr_n_s     = address_b;
                wdata_n_s    = wdata;
                mbe_n_s      = mbe;
            end
        end else begin
            grant_s = 1'b0;
        end
    end

    // next-state, beat counter and line buffer control
    always_comb begin
        state_n_s   = state_r;
        beat_n_s    = beat_r;
        load_en_s   = 1'b0;
        merge_en_s  = 1'b0;
        last_beat_s = (beat_r == BEAT_IDX_W'(BEATS - 1));
        case (state_r)
            IDLE: begin
                beat_n_s = {BEAT_IDX_W{1'b0}};
                if (grant_s) begin
                    if (op_write_n_s && (mbe_n_s == {MBE_W{1'b0}})) begin
                        state_n_s = RESP;
                    end else begin
                        state_n_s = RD_BURST;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            RD_BURST: begin
                if (pmem_resp) begin
                    load_en_s = 1'b1;
                    beat_n_s  = beat_r + BEAT_IDX_W'(1);
                    if (last_beat_s) begin
                        state_n_s = op_write_r ? MERGE : RESP;
                    end else begin
                        state_n_s = RD_BURST;
                    end
                end else begin
                    state_n_s = RD_BURST;
                end
            end
            MERGE: begin
                merge_en_s = 1'b1;
                beat_n_s   = {BEAT_IDX_W{1'b0}};
                state_n_s  = WR_BURST;
            end
            WR_BURST: begin
                if (pmem_resp) begin
                    beat_n_s = beat_r + BEAT_IDX_W'(1);
                    if (last_beat_s) begin
                        state_n_s = RESP;
                    end else begin
                        state_n_s = WR_BURST;
                    end
                end else begin
                    state_n_s = WR_BURST;
                end
            end
            RESP: begin
                beat_n_s  = {BEAT_IDX_W{1'b0}};
                state_n_s = IDLE;
            end
            default: begin
                beat_n_s  = {BEAT_IDX_W{1'b0}};
                state_n_s = IDLE;
            end
        endcase
    end

    // FSM state, beat counter and latched request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            beat_r       <= {BEAT_IDX_W{1'b0}};
            last_grant_r <= PORT_B;
            gnt_port_r   <= PORT_A;
            op_write_r   <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {WORD_W{1'b0}};
            mbe_r        <= {MBE_W{1'b0}};
        end else begin
            state_r    <= state_n_s;
            beat_r     <= beat_n_s;
            gnt_port_r <= gnt_port_n_s;
            op_write_r <= op_write_n_s;
            addr_r     <= addr_n_s;
            wdata_r    <= wdata_n_s;
            mbe_r      <= mbe_n_s;
            if (grant_s) begin
                last_grant_r <= gnt_port_n_s;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= {ADDR_W{1'b0}};
            pmem_wdata   <= {BEAT_W{1'b0}};
            resp_a       <= 1'b0;
            resp_b       <= 1'b0;
            rdata_a      <= {WORD_W{1'b0}};
            rdata_b      <= {WORD_W{1'b0}};
        end else begin
            pmem_read  <= (state_n_s == RD_BURST);
            pmem_write <= (state_n_s == WR_BURST);
            pmem_wdata <= (state_n_s == WR_BURST) ? beat_out_s : {BEAT_W{1'b0}};
            resp_a     <= (state_n_s == RESP) && (gnt_port_n_s == PORT_A);
            resp_b     <= (state_n_s == RESP) && (gnt_port_n_s == PORT_B);
            if (grant_s) begin
                pmem_address <= line_align(addr_n_s);
            end
            if ((state_r == RD_BURST) && (state_n_s == RESP)) begin
                if (gnt_port_r == PORT_A) begin
                    rdata_a <= word_out_s;
                end else begin
                    rdata_b <= word_out_s;
                end
            end
        end
    end

    split_mem_arbiter_line_beat_buffer u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en_s),
        .load_beat  (beat_r),
        .load_data  (pmem_rdata),
        .merge_en   (merge_en_s),
        .word_idx   (word_index(addr_r)),
        .merge_word (wdata_r),
        .merge_mbe  (mbe_r),
        .rd_beat    (beat_n_s),
        .beat_out   (beat_out_s),
        .word_out   (word_out_s)
    );

endmodule

// File: tb/tb_split_mem_arbiter.sv
// Directed bench for split_mem_arbiter: burst memory model plus an expected-response queue.
`timescale 1ns/1ps
module tb_split_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_a;
    logic [31:0] address_a;
    logic [31:0] rdata_a;
    logic        resp_a;
    logic        read_b;
    logic        write;
    logic [31:0] address_b;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    logic [31:0] rdata_b;
    logic        resp_b;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    always #5 clk = ~clk;

    split_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .read_a       (read_a),
        .address_a    (address_a),
        .rdata_a      (rdata_a),
        .resp_a       (resp_a),
        .read_b       (read_b),
        .write        (write),
        .address_b    (address_b),
        .wdata        (wdata),
        .mbe          (mbe),
        .rdata_b      (rdata_b),
        .resp_b       (resp_b),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    logic [255:0] mem     [0:15];
    logic [255:0] ref_mem [0:15];
    bit           mem_ready = 1'b0;
    logic         model_en;
    logic         gap_mode;
    logic         gap_tgl;
    logic         mdl_resp;
    logic [63:0]  mdl_rdata;
    logic         man_resp;
    logic [63:0]  man_rdata;
    logic [1:0]   mbeat;
    int           rd_beats;
    int           wr_beats;
    logic         overlap_seen;
    logic         illegal_seen;
    logic         addr_moved;
    logic [31:0]  burst_addr;

    assign pmem_resp  = model_en ? mdl_resp  : man_resp;
    assign pmem_rdata = model_en ? mdl_rdata : man_rdata;

    typedef struct packed {
        logic        port;
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [255:0] init_line(input int idx);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            if (idx == 3)      l[32*k +: 32] = 32'h00000013 + 32'(k);
            else if (idx == 4) l[32*k +: 32] = 32'hFFFFFFFF;
            else               l[32*k +: 32] = 32'hA5000000 | (32'(idx) << 8) | 32'(k);
        end
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [255:0] l;
        l = ref_mem[addr[8:5]];
        return l[{addr[4:2], 5'b00000} +: 32];
    endfunction

    // Memory model: one beat per cycle (every other cycle in gap mode), driven at negedge.
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] = init_line(i);
            mem_ready    = 1'b1;
            gap_tgl      = 1'b0;
            rd_beats     = 0;
            wr_beats     = 0;
            overlap_seen = 1'b0;
            illegal_seen = 1'b0;
            addr_moved   = 1'b0;
            burst_addr   = 32'd0;
            mdl_rdata    = 64'd0;
            mbeat        = 2'd0;
        end
        mdl_resp = 1'b0;
        if (pmem_read && pmem_write) overlap_seen = 1'b1;
        if (read_b && write) illegal_seen = 1'b1;
        if (!(pmem_read || pmem_write) || !model_en) begin
            mbeat = 2'd0;
        end else begin
            if (mbeat == 2'd0) burst_addr = pmem_address;
            else if (pmem_address !== burst_addr) addr_moved = 1'b1;
            gap_tgl = ~gap_tgl;
            if (!gap_mode || gap_tgl) begin
                if (pmem_read) begin
                    mdl_rdata = mem[pmem_address[8:5]][{mbeat, 6'b000000} +: 64];
                    rd_beats++;
                end else begin
                    mem[pmem_address[8:5]][{mbeat, 6'b000000} +: 64] = pmem_wdata;
                    wr_beats++;
                end
                mdl_resp = 1'b1;
                mbeat    = mbeat + 2'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_read_a(input logic [31:0] addr);
        read_a    = 1'b1;
        address_a = addr;
        sb_q.push_back(exp_t'{port: 1'b0, is_read: 1'b1, data: ref_word(addr)});
    endtask

    task automatic issue_read_b(input logic [31:0] addr);
        read_b    = 1'b1;
        write     = 1'b0;
        address_b = addr;
        sb_q.push_back(exp_t'{port: 1'b1, is_read: 1'b1, data: ref_word(addr)});
    endtask

    task automatic issue_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] m);
        read_b    = 1'b0;
        write     = 1'b1;
        address_b = addr;
        wdata     = wd;
        mbe       = m;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) ref_mem[addr[8:5]][{addr[4:2], 2'(i), 3'b000} +: 8] = wd[8*i +: 8];
        end
        sb_q.push_back(exp_t'{port: 1'b1, is_read: 1'b0, data: 32'd0});
    endtask

    // Waits (bounded) for the next response, pops the expected entry and drops that request.
    task automatic wait_resp(input string tag, output int lat);
        exp_t e;
        bit   got;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (resp_a || resp_b) begin
                got = 1'b1;
                lat = i;
            end
        end
        check({tag, " resp seen"}, 64'(got), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e = exp_t'{port: 1'b0, is_read: 1'b0, data: 32'd0};
        end
        if (got) begin
            check({tag, " port"}, 64'(resp_b), 64'(e.port));
            check({tag, " single resp"}, 64'(resp_a & resp_b), 64'd0);
            if (e.is_read) check({tag, " rdata"}, 64'(resp_b ? rdata_b : rdata_a), 64'(e.data));
        end
        if (resp_a || !got) read_a = 1'b0;
        if (resp_b || !got) begin
            read_b = 1'b0;
            write  = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int rd0;
        int wr0;
        rst       = 1'b1;
        read_a    = 1'b0;
        address_a = 32'd0;
        read_b    = 1'b0;
        write     = 1'b0;
        address_b = 32'd0;
        wdata     = 32'd0;
        mbe       = 4'd0;
        model_en  = 1'b1;
        gap_mode  = 1'b0;
        man_resp  = 1'b0;
        man_rdata = 64'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_line(i);

        // both ports request out of reset: a wins the first tie
        issue_read_a(32'h00000040);
        issue_read_b(32'h00000024);
        repeat (3) @(negedge clk);
        check("reset resp_a", 64'(resp_a), 64'd0);
        check("reset resp_b", 64'(resp_b), 64'd0);
        check("reset pmem_read", 64'(pmem_read), 64'd0);
        check("reset pmem_write", 64'(pmem_write), 64'd0);
        check("reset pmem_address", 64'(pmem_address), 64'd0);
        check("reset pmem_wdata", pmem_wdata, 64'd0);
        check("reset rdata_a", 64'(rdata_a), 64'd0);
        check("reset rdata_b", 64'(rdata_b), 64'd0);
        rd0 = rd_beats;
        rst = 1'b0;
        wait_resp("tie a first", lat);
        wait_resp("tie b second", lat);
        check("tie read beats", 64'(rd_beats - rd0), 64'd8);
        check("tie no overlap", 64'(overlap_seen), 64'd0);

        // port-a read of line 0x60
        @(negedge clk);
        rd0 = rd_beats;
        issue_read_a(32'h00000060);
        wait_resp("a read 0x60", lat);
        check("a read latency", 64'(lat), 64'd5);
        check("a read beats", 64'(rd_beats - rd0), 64'd4);
        check("a read pmem_address", 64'(burst_addr), 64'h60);
        check("a read word0", 64'(rdata_a), 64'h00000013);

        // port-b read of last word
        @(negedge clk);
        issue_read_b(32'h0000007C);
        wait_resp("b read 0x7C", lat);
        check("b read word7", 64'(rdata_b), 64'h0000001A);
        check("rdata_a held", 64'(rdata_a), 64'h00000013);

        // masked write with stalled memory beats
        @(negedge clk);
        gap_mode = 1'b1;
        rd0 = rd_beats;
        wr0 = wr_beats;
        issue_write(32'h00000084, 32'h11223344, 4'b0101);
        wait_resp("masked write", lat);
        gap_mode = 1'b0;
        check("mwrite read beats", 64'(rd_beats - rd0), 64'd4);
        check("mwrite write beats", 64'(wr_beats - wr0), 64'd4);
        check("mwrite pmem_address", 64'(burst_addr), 64'h80);
        check("rdata_b kept over write", 64'(rdata_b), 64'h0000001A);
        @(negedge clk);
        issue_read_a(32'h00000084);
        wait_resp("readback 0x84", lat);
        check("merged word", 64'(rdata_a), 64'hFF22FF44);
        @(negedge clk);
        issue_read_b(32'h00000080);
        wait_resp("readback 0x80", lat);
        @(negedge clk);
        issue_read_b(32'h0000009C);
        wait_resp("readback 0x9C", lat);

        // round robin: after a-only grant, b wins the next tie
        @(negedge clk);
        issue_read_a(32'h00000008);
        wait_resp("a alone", lat);
        @(negedge clk);
        issue_read_b(32'h00000064);
        issue_read_a(32'h00000044);
        wait_resp("rr b first", lat);
        wait_resp("rr a second", lat);

        // zero-mask write: no memory traffic
        @(negedge clk);
        rd0 = rd_beats;
        wr0 = wr_beats;
        issue_write(32'h00000088, 32'hDEADBEEF, 4'b0000);
        wait_resp("zero-mask write", lat);
        check("zero-mask within 2", 64'(lat <= 2), 64'd1);
        check("zero-mask no reads", 64'(rd_beats - rd0), 64'd0);
        check("zero-mask no writes", 64'(wr_beats - wr0), 64'd0);
        @(negedge clk);
        issue_read_b(32'h00000088);
        wait_resp("readback 0x88", lat);

        // reset after beat 1 of a read, then a late pmem_resp in IDLE
        @(negedge clk);
        model_en  = 1'b0;
        read_a    = 1'b1;
        address_a = 32'h00000060;
        @(negedge clk);
        check("abort pmem_read up", 64'(pmem_read), 64'd1);
        man_resp  = 1'b1;
        man_rdata = 64'hBAD00000_00000000;
        @(negedge clk);
        man_rdata = 64'hBAD00000_00000001;
        @(negedge clk);
        man_resp = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("abort pmem_read low", 64'(pmem_read), 64'd0);
        check("abort no resp_a", 64'(resp_a), 64'd0);
        rst      = 1'b0;
        read_a   = 1'b0;
        man_resp = 1'b1;
        @(negedge clk);
        man_resp = 1'b0;
        check("late resp pmem_read", 64'(pmem_read), 64'd0);
        check("late resp pmem_write", 64'(pmem_write), 64'd0);
        check("late resp no resp", 64'(resp_a | resp_b), 64'd0);
        @(negedge clk);
        check("late resp idle", 64'(resp_a | resp_b | pmem_read | pmem_write), 64'd0);
        model_en = 1'b1;
        @(negedge clk);
        rd0 = rd_beats;
        issue_read_a(32'h00000064);
        wait_resp("read after abort", lat);
        check("after abort word1", 64'(rdata_a), 64'h00000014);
        check("after abort beats", 64'(rd_beats - rd0), 64'd4);

        check("never overlapped", 64'(overlap_seen), 64'd0);
        check("no read_b+write", 64'(illegal_seen), 64'd0);
        check("address stable", 64'(addr_moved), 64'd0);
        check("queue drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
